// File: rtl/rdmap_pkg.sv
// rtl/rdmap_pkg.sv - register map, WQE layout, status bits and FSM states for the WQE assembler
package rdmap_pkg;

    localparam int ENTRY_W = 112;

    // Word addresses on the host-facing slave.
    localparam logic [7:0] ADDR_W0       = 8'd0;
    localparam logic [7:0] ADDR_W1       = 8'd1;
    localparam logic [7:0] ADDR_W2       = 8'd2;
    localparam logic [7:0] ADDR_W3       = 8'd3;
    localparam logic [7:0] ADDR_DOORBELL = 8'd4;
    localparam logic [7:0] ADDR_STATUS   = 8'd5;
    localparam logic [7:0] ADDR_POSTED   = 8'd6;

    // WQE field slices.
    localparam int LADDR_LSB = 0;
    localparam int RADDR_LSB = 32;
    localparam int LEN_LSB   = 64;
    localparam int OPTAG_LSB = 96;
    localparam int OPTAG_W   = 16;

    // STATUS register bit positions.
    localparam int ST_FULL_BIT       = 0;
    localparam int ST_INCOMPLETE_BIT = 1;
    localparam int ST_DROPPED_BIT    = 2;
    localparam int ST_STALL_BIT      = 3;
    localparam int ST_DEPTH_LSB      = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_PUSH  = 2'd2
    } wqe_state_e;

    function automatic logic [ENTRY_W-1:0] pack_wqe(input logic [31:0] w0,
                                                    input logic [31:0] w1,
                                                    input logic [31:0] w2,
                                                    input logic [OPTAG_W-1:0] w3);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[LADDR_LSB +: 32]      = w0;
        e[RADDR_LSB +: 32]      = w1;
        e[LEN_LSB +: 32]        = w2;
        e[OPTAG_LSB +: OPTAG_W] = w3;
        return e;
    endfunction

endpackage

// File: rtl/wqe_stage_regs.sv
// rtl/wqe_stage_regs.sv - byte-enabled W0-W3 staging words with per-word valid mask
// Ports: clock/reset (async, active-high); wr_en/wr_sel/wr_be/wr_data stage one word;
//        clr_valid empties the mask; w0_o..w3_o staged words (w3_o upper half always 0);
//        valid_o one bit per word written since the last clear.
module wqe_stage_regs (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        clr_valid,
    output logic [31:0] w0_o,
    output logic [31:0] w1_o,
    output logic [31:0] w2_o,
    output logic [31:0] w3_o,
    output logic [3:0]  valid_o
);
    logic [3:0][31:0] word_q, word_d;
    logic [3:0]       valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (clr_valid) begin
            valid_d = '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) word_d[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
            end
            // A write marks the word valid even with no lane enabled.
            valid_d[wr_sel] = 1'b1;
        end
        // W3 only carries 16 bits; the upper half reads back as zero.
        word_d[3][31:16] = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            valid_q <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign w0_o    = word_q[0];
    assign w1_o    = word_q[1];
    assign w2_o    = word_q[2];
    assign w3_o    = word_q[3];
    assign valid_o = valid_q;

endmodule

// File: rtl/wqe_assembler.sv
// rtl/wqe_assembler.sv - Avalon-MM slave assembling a 112-bit WQE and pushing it on doorbell
// Ports: clock/reset (async, active-high); Avalon slave Address_i, ByteEnable_i, ChipSelect_i,
//        Read_i, Write_i, WriteData_i, ReadData_o, WaitRequest_o; queue FIFO FifoFull_i,
//        FifoDepth_i, WqeData_o, WqePush_o.
// Option: WQE_ASSEMBLER_AUTO_DOORBELL_EN makes a W3 write also ring the doorbell.
module wqe_assembler
    import rdmap_pkg::*;
#(
    parameter int DEPTH_W   = 5,
    parameter int STALL_MAX = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         Address_i,
    input  logic [3:0]         ByteEnable_i,
    input  logic               ChipSelect_i,
    input  logic               Read_i,
    input  logic               Write_i,
    input  logic [31:0]        WriteData_i,
    output logic [31:0]        ReadData_o,
    output logic               WaitRequest_o,
    input  logic               FifoFull_i,
    input  logic [DEPTH_W-1:0] FifoDepth_i,
    output logic [ENTRY_W-1:0] WqeData_o,
    output logic               WqePush_o
);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    wqe_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        posted_q, posted_d;
    logic               incomplete_q, incomplete_d;
    logic               dropped_q, dropped_d;
    logic               rd_pend_q, rd_pend_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [ENTRY_W-1:0] wqe_q, wqe_d;

    logic        wr_acc, rd_acc, is_idle, db_hit, stage_wr, mask_full, stall_done;
    logic        wait_req, push, set_incomplete, set_dropped, clr_mask;
    logic [3:0]  valid, mask_after;
    logic [31:0] w0, w1, w2, w3, status, rd_word;
    logic [ENTRY_W-1:0] entry;

    // Read and Write together count as a write.
    assign wr_acc  = ChipSelect_i && Write_i;
    assign rd_acc  = ChipSelect_i && Read_i && !Write_i;
    assign is_idle = (state_q == S_IDLE);

`ifdef WQE_ASSEMBLER_AUTO_DOORBELL_EN
    assign db_hit = wr_acc && (Address_i == ADDR_DOORBELL || Address_i == ADDR_W3);
`else
    assign db_hit = wr_acc && (Address_i == ADDR_DOORBELL);
`endif

    // Staging is only open in IDLE; elsewhere the bus is held by a doorbell.
    assign stage_wr   = is_idle && wr_acc && (Address_i[7:2] == 6'd0);
    // Include the word being staged this cycle so an implicit doorbell sees it.
    assign mask_after = valid | (4'(stage_wr) << Address_i[1:0]);
    assign mask_full  = &mask_after;
    assign stall_done = (count_q == CNT_W'(STALL_MAX));
    assign entry      = pack_wqe(w0, w1, w2, w3[OPTAG_W-1:0]);

    wqe_stage_regs u_stage (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (stage_wr),
        .wr_sel    (Address_i[1:0]),
        .wr_be     (ByteEnable_i),
        .wr_data   (WriteData_i),
        .clr_valid (clr_mask),
        .w0_o      (w0),
        .w1_o      (w1),
        .w2_o      (w2),
        .w3_o      (w3),
        .valid_o   (valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (db_hit && mask_full) state_d = FifoFull_i ? S_STALL : S_PUSH;
            S_STALL: if (!FifoFull_i)         state_d = S_PUSH;
                     else if (stall_done)     state_d = S_IDLE;
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_req       = 1'b0;
        push           = 1'b0;
        set_incomplete = 1'b0;
        set_dropped    = 1'b0;
        clr_mask       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (db_hit) begin
                    if (mask_full) wait_req = 1'b1;
                    else           set_incomplete = 1'b1;
                end else if (rd_acc && !rd_pend_q) begin
                    wait_req = 1'b1;
                end
            end
            S_STALL: begin
                // Timeout releases the held doorbell in the same cycle it is dropped.
                if (FifoFull_i && stall_done) begin
                    set_dropped = 1'b1;
                    clr_mask    = 1'b1;
                end else begin
                    wait_req = 1'b1;
                end
            end
            S_PUSH: begin
                push     = 1'b1;
                clr_mask = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        status                           = '0;
        status[ST_FULL_BIT]              = FifoFull_i;
        status[ST_INCOMPLETE_BIT]        = incomplete_q;
        status[ST_DROPPED_BIT]           = dropped_q;
        status[ST_STALL_BIT]             = (state_q == S_STALL);
        status[ST_DEPTH_LSB +: DEPTH_W]  = FifoDepth_i;
        case (Address_i)
            ADDR_W0:     rd_word = w0;
            ADDR_W1:     rd_word = w1;
            ADDR_W2:     rd_word = w2;
            ADDR_W3:     rd_word = w3;
            ADDR_STATUS: rd_word = status;
            ADDR_POSTED: rd_word = {16'd0, posted_q};
            default:     rd_word = '0;
        endcase
    end

    always_comb begin
        count_d      = (state_q == S_STALL) ? count_q + CNT_W'(1) : '0;
        posted_d     = posted_q;
        incomplete_d = incomplete_q || set_incomplete;
        dropped_d    = dropped_q || set_dropped;
        if (push) begin
            posted_d = posted_q + 16'd1;
        end else if (is_idle && wr_acc && Address_i == ADDR_POSTED) begin
            posted_d     = '0;
            incomplete_d = 1'b0;
            dropped_d    = 1'b0;
        end
        wqe_d     = push ? entry : wqe_q;
        rd_pend_d = is_idle && rd_acc && !rd_pend_q;
        rdata_d   = rd_pend_d ? rd_word : rdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            posted_q     <= '0;
            incomplete_q <= 1'b0;
            dropped_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rdata_q      <= '0;
            wqe_q        <= '0;
        end else begin
            count_q      <= count_d;
            posted_q     <= posted_d;
            incomplete_q <= incomplete_d;
            dropped_q    <= dropped_d;
            rd_pend_q    <= rd_pend_d;
            rdata_q      <= rdata_d;
            wqe_q        <= wqe_d;
        end
    end

    assign ReadData_o    = rdata_q;
    assign WaitRequest_o = wait_req;
    assign WqePush_o     = push;
    assign WqeData_o     = push ? entry : wqe_q;

endmodule

// File: tb/tb_wqe_assembler.sv
// tb/tb_wqe_assembler.sv - scoreboard bench for wqe_assembler
module tb_wqe_assembler;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   Address_i = '0;
    logic [3:0]   ByteEnable_i = '0;
    logic         ChipSelect_i = 1'b0;
    logic         Read_i = 1'b0;
    logic         Write_i = 1'b0;
    logic [31:0]  WriteData_i = '0;
    logic [31:0]  ReadData_o;
    logic         WaitRequest_o;
    logic         FifoFull_i = 1'b0;
    logic [4:0]   FifoDepth_i = 5'd3;
    logic [111:0] WqeData_o;
    logic         WqePush_o;

`ifdef WQE_ASSEMBLER_AUTO_DOORBELL_EN
    localparam logic [7:0] TRIG_ADDR = 8'd3;
`else
    localparam logic [7:0] TRIG_ADDR = 8'd4;
`endif

    int n_pass = 0;
    int n_total = 0;
    logic [111:0] exp_q[$];

    always #5 clock = ~clock;

    wqe_assembler dut (
        .clock         (clock),
        .reset         (reset),
        .Address_i     (Address_i),
        .ByteEnable_i  (ByteEnable_i),
        .ChipSelect_i  (ChipSelect_i),
        .Read_i        (Read_i),
        .Write_i       (Write_i),
        .WriteData_i   (WriteData_i),
        .ReadData_o    (ReadData_o),
        .WaitRequest_o (WaitRequest_o),
        .FifoFull_i    (FifoFull_i),
        .FifoDepth_i   (FifoDepth_i),
        .WqeData_o     (WqeData_o),
        .WqePush_o     (WqePush_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every push must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && WqePush_o) begin
            if (exp_q.size() == 0) check("unexpected_push", WqePush_o, 1'b0);
            else                   check("push_data", WqeData_o, exp_q.pop_front());
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d,
                             output int waits);
        waits = 0;
        @(negedge clock);
        ChipSelect_i = 1'b1; Write_i = 1'b1; Address_i = a; ByteEnable_i = be; WriteData_i = d;
        #1;
        while (WaitRequest_o && waits < 1000) begin
            waits++;
            @(negedge clock);
            #1;
        end
        if (waits >= 1000) check("write_timeout", waits, 0);
        @(posedge clock);
        #1;
        ChipSelect_i = 1'b0; Write_i = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clock);
        ChipSelect_i = 1'b1; Read_i = 1'b1; Address_i = a;
        #1;
        while (WaitRequest_o && waits < 1000) begin
            waits++;
            @(negedge clock);
            #1;
        end
        if (waits >= 1000) check("read_timeout", waits, 0);
        d = ReadData_o;
        @(posedge clock);
        #1;
        ChipSelect_i = 1'b0; Read_i = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int w;
        bus_read(a, d, w);
        check(name, d, exp);
    endtask

    // Stage every word except the one whose write rings the doorbell.
    task automatic stage_all(input logic [31:0] w0, w1, w2, w3);
        int w;
        bus_write(8'd0, 4'hF, w0, w);
        bus_write(8'd1, 4'hF, w1, w);
        bus_write(8'd2, 4'hF, w2, w);
`ifndef WQE_ASSEMBLER_AUTO_DOORBELL_EN
        bus_write(8'd3, 4'hF, w3, w);
`endif
    endtask

    initial begin
        int w;
        logic [31:0] d;

        // Reset state
        #1;
        check("rst_readdata", ReadData_o, 32'h0);
        check("rst_waitreq", WaitRequest_o, 1'b0);
        check("rst_wqedata", WqeData_o, 112'h0);
        check("rst_push", WqePush_o, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_read("rst_posted", 8'd6, 32'h0);
        check_read("rst_status", 8'd5, 32'h0000_0300);

        // Basic post; W3 upper half must be ignored
        stage_all(32'h11111111, 32'h22222222, 32'h00000040, 32'hFFFFA5C3);
        exp_q.push_back(112'hA5C3_00000040_22222222_11111111);
        bus_write(TRIG_ADDR, 4'hF, 32'hFFFFA5C3, w);
        check("db_waits", w, 1);
        bus_read(8'd6, d, w);
        check("posted_1", d, 32'd1);
        check("read_waits", w, 1);
        check("wqe_hold", WqeData_o, 112'hA5C3_00000040_22222222_11111111);
        check_read("w3_readback", 8'd3, 32'h0000A5C3);
        check_read("db_reads_zero", 8'd4, 32'h0);
        check_read("hi_addr_zero", 8'd200, 32'h0);

        // Incomplete doorbell
        bus_write(8'd0, 4'hF, 32'h1, w);
        bus_write(8'd1, 4'hF, 32'h2, w);
        bus_write(8'd2, 4'hF, 32'h3, w);
        bus_write(8'd4, 4'hF, 32'h0, w);
        check("incomplete_waits", w, 0);
        check_read("incomplete_status", 8'd5, 32'h0000_0302);
        check_read("incomplete_posted", 8'd6, 32'd1);
        bus_write(8'd6, 4'hF, 32'h0, w);
        check_read("clear_status", 8'd5, 32'h0000_0300);
        check_read("clear_posted", 8'd6, 32'd0);

        // Stall for 10 cycles then release
        stage_all(32'hAAAA0001, 32'hBBBB0002, 32'h00000100, 32'h00001234);
        exp_q.push_back(112'h1234_00000100_BBBB0002_AAAA0001);
        FifoFull_i = 1'b1;
        fork
            bus_write(TRIG_ADDR, 4'hF, 32'h00001234, w);
            begin
                @(negedge clock);
                repeat (10) @(negedge clock);
                FifoFull_i = 1'b0;
            end
        join
        check("stall_waits", w, 11);
        check_read("stall_posted", 8'd6, 32'd1);
        check_read("stall_status", 8'd5, 32'h0000_0300);

        // Stall timeout drops the entry and clears the mask
        stage_all(32'h5, 32'h6, 32'h7, 32'h8);
        FifoFull_i = 1'b1;
        bus_write(TRIG_ADDR, 4'hF, 32'h8, w);
        check("drop_waits", w, 256);
        FifoFull_i = 1'b0;
        check_read("drop_status", 8'd5, 32'h0000_0304);
        check_read("drop_posted", 8'd6, 32'd1);
        bus_write(8'd4, 4'hF, 32'h0, w);
        check("drop_mask_cleared", w, 0);
        check_read("drop_incomplete", 8'd5, 32'h0000_0306);
        bus_write(8'd6, 4'hF, 32'h0, w);

        // Byte enables
        bus_write(8'd1, 4'hF, 32'hFFFFFFFF, w);
        bus_write(8'd1, 4'b0001, 32'h000000AB, w);
        bus_read(8'd1, d, w);
        check("be_data", d, 32'hFFFFFFAB);
        check("be_read_waits", w, 1);

        // Reset during stall
        stage_all(32'h9, 32'hA, 32'hB, 32'hC);
        FifoFull_i = 1'b1;
        @(negedge clock);
        ChipSelect_i = 1'b1; Write_i = 1'b1; Address_i = TRIG_ADDR; ByteEnable_i = 4'hF;
        WriteData_i = 32'hC;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_readdata", ReadData_o, 32'h0);
        check("mid_rst_waitreq", WaitRequest_o, 1'b0);
        check("mid_rst_wqedata", WqeData_o, 112'h0);
        check("mid_rst_push", WqePush_o, 1'b0);
        @(negedge clock);
        ChipSelect_i = 1'b0; Write_i = 1'b0; FifoFull_i = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_read("mid_rst_posted", 8'd6, 32'd0);
        check_read("mid_rst_status", 8'd5, 32'h0000_0300);

        // Post after reset needs a freshly staged entry
        stage_all(32'hC0DE0000, 32'h0000BEEF, 32'h00000800, 32'h00000077);
        exp_q.push_back(112'h0077_00000800_0000BEEF_C0DE0000);
        bus_write(TRIG_ADDR, 4'hF, 32'h00000077, w);
        check("final_waits", w, 1);
        check_read("final_posted", 8'd6, 32'd1);

        repeat (3) @(negedge clock);
        check("pushes_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
